// File: rtl/hyper_pkg.sv
// Shared types and sizing helpers for the HyperBus AXI drain/isolation gate.
package hyper_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } gate_state_e;

  // Width of an outstanding-transaction counter that must hold 0..max_trans.
  function automatic int unsigned cnt_width(input int unsigned max_trans);
    return (max_trans < 1) ? 1 : $clog2(max_trans + 1);
  endfunction

endpackage

// File: rtl/hyper_drain_gate_port.sv
// One AXI port of the drain gate: outstanding counters, hold flags, drain FSM and
// combinational gating of the AW/AR handshakes.
module hyper_drain_gate_port
  import hyper_pkg::*;
#(
  parameter int unsigned MaxTrans      = 8,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic isolate_i,
  output logic isolated_o,
  output logic timeout_o,
  input  logic slv_aw_valid_i,
  output logic slv_aw_ready_o,
  output logic mst_aw_valid_o,
  input  logic mst_aw_ready_i,
  input  logic slv_ar_valid_i,
  output logic slv_ar_ready_o,
  output logic mst_ar_valid_o,
  input  logic mst_ar_ready_i,
  input  logic mst_b_valid_i,
  input  logic slv_b_ready_i,
  input  logic mst_r_valid_i,
  input  logic slv_r_ready_i,
  input  logic mst_r_last_i
);

  localparam int unsigned CntW   = cnt_width(MaxTrans);
  localparam int unsigned DrainW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0]   CntMax      = CntW'(MaxTrans);
  localparam logic [DrainW-1:0] TimeoutLast = (TimeoutCycles > 0) ? DrainW'(TimeoutCycles - 1) : '0;

  gate_state_e       state;
  logic [CntW-1:0]   wr_cnt, rd_cnt;
  logic [DrainW-1:0] drain_cnt;
  logic              hold_aw, hold_ar;
  logic              allow_aw, allow_ar;
  logic              aw_hs, ar_hs, b_hs, r_hs, drained;

  // A held handshake bypasses both the state and saturation so a presented valid never retracts.
  assign allow_aw = (state == RUN && wr_cnt < CntMax) || hold_aw;
  assign allow_ar = (state == RUN && rd_cnt < CntMax) || hold_ar;

  assign mst_aw_valid_o = slv_aw_valid_i & allow_aw;
  assign slv_aw_ready_o = mst_aw_ready_i & allow_aw;
  assign mst_ar_valid_o = slv_ar_valid_i & allow_ar;
  assign slv_ar_ready_o = mst_ar_ready_i & allow_ar;

  assign aw_hs   = mst_aw_valid_o & mst_aw_ready_i;
  assign ar_hs   = mst_ar_valid_o & mst_ar_ready_i;
  assign b_hs    = mst_b_valid_i & slv_b_ready_i;
  assign r_hs    = mst_r_valid_i & slv_r_ready_i & mst_r_last_i;
  assign drained = (wr_cnt == '0) && (rd_cnt == '0) && !hold_aw && !hold_ar;

  function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                               input logic inc, input logic dec);
    if (inc && !dec) return cnt + CntW'(1);
    if (dec && !inc && cnt != '0) return cnt - CntW'(1);
    return cnt;
  endfunction

  // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= RUN;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      drain_cnt  <= '0;
      hold_aw    <= 1'b0;
      hold_ar    <= 1'b0;
      isolated_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      wr_cnt <= next_cnt(wr_cnt, aw_hs, b_hs);
      rd_cnt <= next_cnt(rd_cnt, ar_hs, r_hs);

      if (aw_hs)               hold_aw <= 1'b0;
      else if (mst_aw_valid_o) hold_aw <= 1'b1;
      if (ar_hs)               hold_ar <= 1'b0;
      else if (mst_ar_valid_o) hold_ar <= 1'b1;

      unique case (state)
        RUN: begin
          if (isolate_i) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (!isolate_i) begin
            state     <= RUN;
            drain_cnt <= '0;
            timeout_o <= 1'b0;
          end else begin
            if (drained) begin
              state      <= ISOLATED;
              isolated_o <= 1'b1;
            end
            // Saturates at the timeout point; timeout_o is sticky from there on.
            if (drain_cnt != TimeoutLast) drain_cnt <= drain_cnt + DrainW'(1);
            if (TimeoutCycles > 0 && drain_cnt == TimeoutLast) timeout_o <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_i) begin
            state      <= RUN;
            isolated_o <= 1'b0;
            timeout_o  <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  a_wr_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_hs && !aw_hs && wr_cnt == '0));
  a_rd_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_hs && !ar_hs && rd_cnt == '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wr_cnt <= CntMax) && (rd_cnt <= CntMax));
  a_aw_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_aw_valid_o && !mst_aw_ready_i) |=> mst_aw_valid_o);
  a_ar_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_ar_valid_o && !mst_ar_ready_i) |=> mst_ar_valid_o);
  a_isolated_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    isolated_o |-> drained);

endmodule

// File: rtl/hyper_axi_drain_gate.sv
// Multi-port AXI isolation/drain gate; each port is an independent hyper_drain_gate_port.
module hyper_axi_drain_gate
  import hyper_pkg::*;
#(
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned MaxTrans      = 8,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPorts-1:0] isolate_i,
  output logic [NumPorts-1:0] isolated_o,
  output logic [NumPorts-1:0] timeout_o,
  input  logic [NumPorts-1:0] slv_aw_valid_i,
  output logic [NumPorts-1:0] slv_aw_ready_o,
  output logic [NumPorts-1:0] mst_aw_valid_o,
  input  logic [NumPorts-1:0] mst_aw_ready_i,
  input  logic [NumPorts-1:0] slv_ar_valid_i,
  output logic [NumPorts-1:0] slv_ar_ready_o,
  output logic [NumPorts-1:0] mst_ar_valid_o,
  input  logic [NumPorts-1:0] mst_ar_ready_i,
  input  logic [NumPorts-1:0] mst_b_valid_i,
  input  logic [NumPorts-1:0] slv_b_ready_i,
  input  logic [NumPorts-1:0] mst_r_valid_i,
  input  logic [NumPorts-1:0] slv_r_ready_i,
  input  logic [NumPorts-1:0] mst_r_last_i
);

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    hyper_drain_gate_port #(
      .MaxTrans      (MaxTrans),
      .TimeoutCycles (TimeoutCycles)
    ) u_port (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .isolate_i      (isolate_i[p]),
      .isolated_o     (isolated_o[p]),
      .timeout_o      (timeout_o[p]),
      .slv_aw_valid_i (slv_aw_valid_i[p]),
      .slv_aw_ready_o (slv_aw_ready_o[p]),
      .mst_aw_valid_o (mst_aw_valid_o[p]),
      .mst_aw_ready_i (mst_aw_ready_i[p]),
      .slv_ar_valid_i (slv_ar_valid_i[p]),
      .slv_ar_ready_o (slv_ar_ready_o[p]),
      .mst_ar_valid_o (mst_ar_valid_o[p]),
      .mst_ar_ready_i (mst_ar_ready_i[p]),
      .mst_b_valid_i  (mst_b_valid_i[p]),
      .slv_b_ready_i  (slv_b_ready_i[p]),
      .mst_r_valid_i  (mst_r_valid_i[p]),
      .slv_r_ready_i  (slv_r_ready_i[p]),
      .mst_r_last_i   (mst_r_last_i[p])
    );
  end

endmodule

// File: tb/tb_hyper_axi_drain_gate.sv
// Self-checking bench for hyper_axi_drain_gate: drain, saturation, hold, timeout, reset.
module tb_hyper_axi_drain_gate;

  localparam int unsigned NP = 2;
  localparam int unsigned MT = 8;
  localparam int unsigned TC = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [NP-1:0] isolate_i, isolated_o, timeout_o;
  logic [NP-1:0] slv_aw_valid_i, slv_aw_ready_o, mst_aw_valid_o, mst_aw_ready_i;
  logic [NP-1:0] slv_ar_valid_i, slv_ar_ready_o, mst_ar_valid_o, mst_ar_ready_i;
  logic [NP-1:0] mst_b_valid_i, slv_b_ready_i;
  logic [NP-1:0] mst_r_valid_i, slv_r_ready_i, mst_r_last_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [1:0] exp;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hyper_axi_drain_gate #(
    .NumPorts      (NP),
    .MaxTrans      (MT),
    .TimeoutCycles (TC)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .isolate_i      (isolate_i),
    .isolated_o     (isolated_o),
    .timeout_o      (timeout_o),
    .slv_aw_valid_i (slv_aw_valid_i),
    .slv_aw_ready_o (slv_aw_ready_o),
    .mst_aw_valid_o (mst_aw_valid_o),
    .mst_aw_ready_i (mst_aw_ready_i),
    .slv_ar_valid_i (slv_ar_valid_i),
    .slv_ar_ready_o (slv_ar_ready_o),
    .mst_ar_valid_o (mst_ar_valid_o),
    .mst_ar_ready_i (mst_ar_ready_i),
    .mst_b_valid_i  (mst_b_valid_i),
    .slv_b_ready_i  (slv_b_ready_i),
    .mst_r_valid_i  (mst_r_valid_i),
    .slv_r_ready_i  (slv_r_ready_i),
    .mst_r_last_i   (mst_r_last_i)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    isolate_i      = '0;
    slv_aw_valid_i = '0;
    mst_aw_ready_i = '0;
    slv_ar_valid_i = '0;
    mst_ar_ready_i = '0;
    mst_b_valid_i  = '0;
    slv_b_ready_i  = '0;
    mst_r_valid_i  = '0;
    slv_r_ready_i  = '0;
    mst_r_last_i   = '0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    idle_inputs();
    step(2);
    settle();
    n_checks++;
    if (isolated_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_isolated: got %b want %b", isolated_o, 2'b00);
    end
    n_checks++;
    if (timeout_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_timeout: got %b want %b", timeout_o, 2'b00);
    end
    rst_ni = 1'b1;
    step();
    mst_aw_ready_i = 2'b11;
    mst_ar_ready_i = 2'b11;
    settle();
    n_checks++;
    if ({slv_aw_ready_o, slv_ar_ready_o} !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_ready_pass: got %b want %b", {slv_aw_ready_o, slv_ar_ready_o}, 4'b1111);
    end
    mst_aw_ready_i = 2'b00;
    mst_ar_ready_i = 2'b00;
    step();
  endtask

  // Three writes outstanding on port 0, then isolate; isolation waits for all three B.
  task automatic test_drain_writes;
    slv_aw_valid_i[0] = 1'b1;
    mst_aw_ready_i[0] = 1'b1;
    step(3);
    slv_aw_valid_i[0] = 1'b0;
    mst_aw_ready_i[0] = 1'b0;
    isolate_i[0] = 1'b1;
    step();
    slv_aw_valid_i[0] = 1'b1;
    settle();
    n_checks++;
    if (mst_aw_valid_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_blocks_new_aw: got %b want %b", mst_aw_valid_o[0], 1'b0);
    end
    slv_aw_valid_i[0] = 1'b0;
    step(2);
    settle();
    n_checks++;
    if (isolated_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_not_isolated: got %b want %b", isolated_o[0], 1'b0);
    end
    mst_b_valid_i[0] = 1'b1;
    slv_b_ready_i[0] = 1'b1;
    step(3);
    mst_b_valid_i[0] = 1'b0;
    slv_b_ready_i[0] = 1'b0;
    step();
    settle();
    n_checks++;
    if (isolated_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_isolated_after_b: got %b want %b", isolated_o[0], 1'b1);
    end
    isolate_i[0] = 1'b0;
    step();
    mst_aw_ready_i[0] = 1'b1;
    settle();
    n_checks++;
    if ({isolated_o[0], slv_aw_ready_o[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_release: got %b want %b", {isolated_o[0], slv_aw_ready_o[0]}, 2'b01);
    end
    mst_aw_ready_i[0] = 1'b0;
    step();
  endtask

  // Eight reads fill port 0; the ninth is blocked until one R-last retires a read.
  task automatic test_saturation;
    exp_t x;
    slv_ar_valid_i[0] = 1'b1;
    mst_ar_ready_i[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic e;
      e = (i < 8) || (i == 10);
      mst_r_valid_i[0] = (i == 9);
      slv_r_ready_i[0] = (i == 9);
      mst_r_last_i[0]  = (i == 9);
      sb_q.push_back('{name: $sformatf("sat_ar_accept_%0d", i), exp: {e, e}});
      settle();
      x = sb_q.pop_front();
      n_checks++;
      if ({slv_ar_ready_o[0], mst_ar_valid_o[0]} !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", x.name, {slv_ar_ready_o[0], mst_ar_valid_o[0]}, x.exp);
      end
      step();
    end
    slv_ar_valid_i[0] = 1'b0;
    mst_ar_ready_i[0] = 1'b0;
    mst_r_valid_i[0]  = 1'b1;
    slv_r_ready_i[0]  = 1'b1;
    mst_r_last_i[0]   = 1'b1;
    step(MT);
    mst_r_valid_i[0]  = 1'b0;
    slv_r_ready_i[0]  = 1'b0;
    mst_r_last_i[0]   = 1'b0;
    step();
  endtask

  // A stalled AW keeps its valid through the drain and must complete before isolation.
  task automatic test_hold;
    slv_aw_valid_i[0] = 1'b1;
    mst_aw_ready_i[0] = 1'b0;
    settle();
    n_checks++;
    if (mst_aw_valid_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_valid_presented: got %b want %b", mst_aw_valid_o[0], 1'b1);
    end
    step();
    isolate_i[0] = 1'b1;
    step(3);
    settle();
    n_checks++;
    if ({mst_aw_valid_o[0], isolated_o[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_valid_kept: got %b want %b", {mst_aw_valid_o[0], isolated_o[0]}, 2'b10);
    end
    mst_aw_ready_i[0] = 1'b1;
    #1;
    n_checks++;
    if (slv_aw_ready_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_ready_passed: got %b want %b", slv_aw_ready_o[0], 1'b1);
    end
    step();
    slv_aw_valid_i[0] = 1'b0;
    mst_aw_ready_i[0] = 1'b0;
    step(3);
    settle();
    n_checks++;
    if (isolated_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_wait_b: got %b want %b", isolated_o[0], 1'b0);
    end
    mst_b_valid_i[0] = 1'b1;
    slv_b_ready_i[0] = 1'b1;
    step();
    mst_b_valid_i[0] = 1'b0;
    slv_b_ready_i[0] = 1'b0;
    step();
    settle();
    n_checks++;
    if (isolated_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_isolated: got %b want %b", isolated_o[0], 1'b1);
    end
    isolate_i[0] = 1'b0;
    step();
  endtask

  // One stuck read on port 1: timeout_o rises exactly TC cycles after DRAIN entry.
  task automatic test_timeout;
    slv_ar_valid_i[1] = 1'b1;
    mst_ar_ready_i[1] = 1'b1;
    step();
    slv_ar_valid_i[1] = 1'b0;
    mst_ar_ready_i[1] = 1'b0;
    isolate_i[1] = 1'b1;
    step();
    for (int k = 1; k < TC; k++) begin
      step();
      settle();
      n_checks++;
      if (timeout_o[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_early_%0d: got %b want %b", k, timeout_o[1], 1'b0);
      end
    end
    step();
    settle();
    n_checks++;
    if ({timeout_o[1], isolated_o[1]} !== 2'b10) begin
      n_fail++;
      $display("FAIL timeout_raised: got %b want %b", {timeout_o[1], isolated_o[1]}, 2'b10);
    end
    mst_r_valid_i[1] = 1'b1;
    slv_r_ready_i[1] = 1'b1;
    mst_r_last_i[1]  = 1'b1;
    step();
    mst_r_valid_i[1] = 1'b0;
    slv_r_ready_i[1] = 1'b0;
    mst_r_last_i[1]  = 1'b0;
    step();
    settle();
    n_checks++;
    if ({timeout_o[1], isolated_o[1]} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_then_isolated: got %b want %b", {timeout_o[1], isolated_o[1]}, 2'b11);
    end
    isolate_i[1] = 1'b0;
    step();
    settle();
    n_checks++;
    if ({timeout_o[1], isolated_o[1]} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_cleared: got %b want %b", {timeout_o[1], isolated_o[1]}, 2'b00);
    end
    step();
  endtask

  // Port 1 isolated while port 0 streams AWs; same-cycle AW+B keeps wr_cnt at 2.
  task automatic test_back_to_back;
    exp_t x;
    isolate_i[1] = 1'b1;
    step(2);
    settle();
    n_checks++;
    if (isolated_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_port1_isolated: got %b want %b", isolated_o[1], 1'b1);
    end
    step();
    for (int j = 0; j < 3; j++) begin
      slv_aw_valid_i   = 2'b11;
      mst_aw_ready_i   = 2'b11;
      mst_b_valid_i[0] = (j == 2);
      slv_b_ready_i[0] = (j == 2);
      sb_q.push_back('{name: $sformatf("b2b_p0_accept_%0d", j), exp: 2'b11});
      sb_q.push_back('{name: $sformatf("b2b_p1_blocked_%0d", j), exp: 2'b00});
      settle();
      x = sb_q.pop_front();
      n_checks++;
      if ({slv_aw_ready_o[0], mst_aw_valid_o[0]} !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", x.name, {slv_aw_ready_o[0], mst_aw_valid_o[0]}, x.exp);
      end
      x = sb_q.pop_front();
      n_checks++;
      if ({slv_aw_ready_o[1], mst_aw_valid_o[1]} !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %b want %b", x.name, {slv_aw_ready_o[1], mst_aw_valid_o[1]}, x.exp);
      end
      step();
    end
    slv_aw_valid_i   = 2'b00;
    mst_aw_ready_i   = 2'b00;
    mst_b_valid_i[0] = 1'b0;
    slv_b_ready_i[0] = 1'b0;
    isolate_i[0] = 1'b1;
    step();
    mst_b_valid_i[0] = 1'b1;
    slv_b_ready_i[0] = 1'b1;
    step();
    mst_b_valid_i[0] = 1'b0;
    slv_b_ready_i[0] = 1'b0;
    step(2);
    settle();
    n_checks++;
    if (isolated_o !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_one_write_left: got %b want %b", isolated_o, 2'b10);
    end
    mst_b_valid_i[0] = 1'b1;
    slv_b_ready_i[0] = 1'b1;
    step();
    mst_b_valid_i[0] = 1'b0;
    slv_b_ready_i[0] = 1'b0;
    step();
    settle();
    n_checks++;
    if (isolated_o !== 2'b11) begin
      n_fail++;
      $display("FAIL b2b_both_isolated: got %b want %b", isolated_o, 2'b11);
    end
    isolate_i = 2'b00;
    step();
    settle();
    n_checks++;
    if (isolated_o !== 2'b00) begin
      n_fail++;
      $display("FAIL b2b_released: got %b want %b", isolated_o, 2'b00);
    end
    step();
  endtask

  // Reset during a timed-out drain with three writes outstanding.
  task automatic test_reset_in_drain;
    slv_aw_valid_i[0] = 1'b1;
    mst_aw_ready_i[0] = 1'b1;
    step(3);
    slv_aw_valid_i[0] = 1'b0;
    mst_aw_ready_i[0] = 1'b0;
    isolate_i[0] = 1'b1;
    step(TC + 2);
    settle();
    n_checks++;
    if ({timeout_o[0], isolated_o[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstdrain_pre: got %b want %b", {timeout_o[0], isolated_o[0]}, 2'b10);
    end
    rst_ni = 1'b0;
    step();
    mst_aw_ready_i[0] = 1'b1;
    settle();
    n_checks++;
    if ({timeout_o[0], isolated_o[0], slv_aw_ready_o[0]} !== 3'b001) begin
      n_fail++;
      $display("FAIL rstdrain_cleared: got %b want %b",
               {timeout_o[0], isolated_o[0], slv_aw_ready_o[0]}, 3'b001);
    end
    mst_aw_ready_i[0] = 1'b0;
    rst_ni = 1'b1;
    step(2);
    settle();
    n_checks++;
    if (isolated_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rstdrain_counts_zero: got %b want %b", isolated_o[0], 1'b1);
    end
    isolate_i[0] = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_drain_writes();
    test_saturation();
    test_hold();
    test_timeout();
    test_back_to_back();
    test_reset_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
